// File: rtl/uart_debug_master.sv
// Serial-to-bus debug master: 8N1 command frames from a host drive 32-bit reads and writes
// on the native valid/ready bus, and the result is returned over the same serial link.

module uart_debug_master #(
   parameter int DIV     = 104,
   parameter int TIMEOUT = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ser_rx,
   output logic        ser_tx,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam logic [15:0] BIT_LAST  = 16'(DIV - 1);
   localparam logic [15:0] HALF_LAST = 16'(DIV / 2 - 1);
   localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);

   localparam logic [7:0] CMD_READ     = 8'h52;
   localparam logic [7:0] CMD_WRITE    = 8'h57;
   localparam logic [7:0] RESP_OK      = 8'h4B;
   localparam logic [7:0] RESP_UNKNOWN = 8'h3F;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {S_CMD, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

   logic        rx_meta, rx_sync, rx_prev;
   rx_state_t   rx_state, rx_state_next;
   logic [15:0] rx_cnt;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shift;
   logic        rx_tick, rx_stb, rx_err;

   state_t      state, state_next;
   logic        is_write;
   logic [1:0]  byte_cnt;
   logic [31:0] to_cnt;
   logic        to_expired;
   logic [23:0] resp_buf;
   logic [1:0]  resp_left;

   logic [9:0]  tx_shift;
   logic [15:0] tx_cnt;
   logic [3:0]  tx_bits;
   logic        tx_active, tx_tick, tx_end, tx_load;
   logic [7:0]  tx_byte;

   assign rx_tick    = (rx_cnt == 16'd0);
   assign rx_stb     = (rx_state == RX_STOP) && rx_tick && rx_sync;
   assign rx_err     = (rx_state == RX_STOP) && rx_tick && !rx_sync;
   assign tx_tick    = (tx_cnt == 16'd0);
   assign tx_end     = tx_active && tx_tick && (tx_bits == 4'd0);
   assign to_expired = (to_cnt == TO_LAST);
   assign ser_tx     = tx_shift[0];
   assign busy       = (state != S_CMD);

   // Receiver bit-timing state; a start edge that is high again at mid-bit is a glitch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rx_state <= RX_IDLE;
      else       rx_state <= rx_state_next;
   end

   always_comb begin
      rx_state_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (rx_prev && !rx_sync) rx_state_next = RX_START;
         RX_START: if (rx_tick) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_next = RX_STOP;
         RX_STOP:  if (rx_tick) rx_state_next = RX_IDLE;
         default:  rx_state_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_prev  <= 1'b1;
         rx_cnt   <= 16'd0;
         rx_bit   <= 3'd0;
         rx_shift <= 8'h00;
      end else begin
         rx_meta <= ser_rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
         case (rx_state)
            RX_IDLE: begin
               rx_cnt <= HALF_LAST;
               rx_bit <= 3'd0;
            end
            RX_DATA: begin
               if (rx_tick) begin
                  rx_shift <= {rx_sync, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 3'd1;
                  rx_cnt   <= BIT_LAST;
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            default: rx_cnt <= rx_tick ? BIT_LAST : rx_cnt - 16'd1;
         endcase
      end
   end

   // Command parser; the first response byte is launched on the same edge the parser enters S_RESP.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_CMD;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      tx_load    = 1'b0;
      tx_byte    = 8'h00;
      case (state)
         S_CMD: begin
            if (rx_stb) begin
               if (rx_shift == CMD_READ || rx_shift == CMD_WRITE) begin
                  state_next = S_ADDR;
               end else begin
                  state_next = S_RESP;
                  tx_load    = 1'b1;
                  tx_byte    = RESP_UNKNOWN;
               end
            end
         end
         S_ADDR: begin
            if (rx_err)                            state_next = S_CMD;
            else if (rx_stb && byte_cnt == 2'd3)   state_next = is_write ? S_DATA : S_BUS;
            else if (!rx_stb && to_expired)        state_next = S_CMD;
         end
         S_DATA: begin
            if (rx_err)                            state_next = S_CMD;
            else if (rx_stb && byte_cnt == 2'd3)   state_next = S_BUS;
            else if (!rx_stb && to_expired)        state_next = S_CMD;
         end
         S_BUS: begin
            if (mem_ready) begin
               state_next = S_RESP;
               tx_load    = 1'b1;
               tx_byte    = is_write ? RESP_OK : mem_rdata[7:0];
            end
         end
         S_RESP: begin
            if (tx_end) begin
               if (resp_left == 2'd0) begin
                  state_next = S_CMD;
               end else begin
                  tx_load = 1'b1;
                  tx_byte = resp_buf[7:0];
               end
            end
         end
         default: state_next = S_CMD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         is_write  <= 1'b0;
         byte_cnt  <= 2'd0;
         to_cnt    <= 32'd0;
         resp_buf  <= 24'h0;
         resp_left <= 2'd0;
         mem_valid <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         mem_wstrb <= 4'h0;
      end else begin
         case (state)
            S_CMD: begin
               byte_cnt  <= 2'd0;
               resp_left <= 2'd0;
               if (rx_stb) is_write <= (rx_shift == CMD_WRITE);
            end
            S_ADDR: begin
               if (rx_stb) begin
                  mem_addr <= {rx_shift, mem_addr[31:8]};
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3 && !is_write) begin
                     mem_valid <= 1'b1;
                     mem_wstrb <= 4'h0;
                  end
               end
            end
            S_DATA: begin
               if (rx_stb) begin
                  mem_wdata <= {rx_shift, mem_wdata[31:8]};
                  byte_cnt  <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     mem_valid <= 1'b1;
                     mem_wstrb <= 4'hF;
                  end
               end
            end
            S_BUS: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  resp_buf  <= mem_rdata[31:8];
                  resp_left <= is_write ? 2'd0 : 2'd3;
               end
            end
            S_RESP: begin
               if (tx_end && resp_left != 2'd0) begin
                  resp_buf  <= {8'h00, resp_buf[23:8]};
                  resp_left <= resp_left - 2'd1;
               end
            end
            default: ;
         endcase
         if ((state == S_ADDR || state == S_DATA) && !rx_stb) to_cnt <= to_cnt + 32'd1;
         else                                                  to_cnt <= 32'd0;
      end
   end

   // Transmitter shifts {stop, data, start} out LSB first; the idle line is the all-ones fill.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_shift  <= 10'h3FF;
         tx_cnt    <= 16'd0;
         tx_bits   <= 4'd0;
         tx_active <= 1'b0;
      end else if (tx_load) begin
         tx_shift  <= {1'b1, tx_byte, 1'b0};
         tx_cnt    <= BIT_LAST;
         tx_bits   <= 4'd9;
         tx_active <= 1'b1;
      end else if (tx_active) begin
         if (tx_tick) begin
            if (tx_bits == 4'd0) begin
               tx_active <= 1'b0;
            end else begin
               tx_shift <= {1'b1, tx_shift[9:1]};
               tx_bits  <= tx_bits - 4'd1;
               tx_cnt   <= BIT_LAST;
            end
         end else begin
            tx_cnt <= tx_cnt - 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_debug_master.sv
// Scoreboard bench for uart_debug_master: directed host frames, a bus slave model,
// and independent monitors that decode the bus handshakes and the serial responses.

module tb_uart_debug_master;

   localparam int DIV     = 4;
   localparam int TIMEOUT = 200;
   localparam int CLK_T   = 10;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [15:0] cycles;
   } bus_exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        ser_rx;
   logic        ser_tx;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        busy;

   bus_exp_t    exp_bus[$];
   logic [7:0]  exp_tx[$];
   time         tx_times[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          ready_delay = 0;

   uart_debug_master #(.DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .ser_rx    (ser_rx),
      .ser_tx    (ser_tx),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   always #(CLK_T / 2) clk = ~clk;

   task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: actual 0x%08h, required 0x%08h", name, actual, expected);
      end
   endtask

   task automatic expect_bus(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, input logic [15:0] cycles);
      bus_exp_t e;
      e.addr   = addr;
      e.wdata  = wdata;
      e.wstrb  = wstrb;
      e.cycles = cycles;
      exp_bus.push_back(e);
   endtask

   task automatic expect_word(input logic [31:0] w);
      exp_tx.push_back(w[7:0]);
      exp_tx.push_back(w[15:8]);
      exp_tx.push_back(w[23:16]);
      exp_tx.push_back(w[31:24]);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap);
      @(negedge clk);
      ser_rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         ser_rx = b[i];
         repeat (DIV) @(negedge clk);
      end
      ser_rx = stop_bit;
      repeat (DIV) @(negedge clk);
      ser_rx = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] addr,
                           input logic [31:0] data, input logic with_data);
      send_byte(cmd, 1'b1, 2 * DIV);
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], 1'b1, 2 * DIV);
      if (with_data)
         for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], 1'b1, 2 * DIV);
   endtask

   // Waits for the command to drain: parser idle and every expected event observed.
   task automatic wait_done(input string name);
      int left;
      left = 3000;
      while ((busy || exp_tx.size() != 0 || exp_bus.size() != 0) && left > 0) begin
         @(negedge clk);
         left--;
      end
      n_checks++;
      if (left == 0) begin
         n_fail++;
         $display("[TB] FAIL %s_timeout: actual busy=%0b pending_tx=%0d pending_bus=%0d, required all zero",
                  name, busy, exp_tx.size(), exp_bus.size());
         exp_tx.delete();
         exp_bus.delete();
      end
   endtask

   // Bus slave: raises mem_ready after ready_delay cycles of mem_valid.
   initial begin
      int wait_cnt;
      wait_cnt  = 0;
      mem_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (mem_valid) begin
            wait_cnt++;
            mem_ready = (wait_cnt > ready_delay);
         end else begin
            wait_cnt  = 0;
            mem_ready = 1'b0;
         end
      end
   end

   // Bus monitor: every handshake must match the head of the bus scoreboard.
   initial begin
      int       vcnt;
      bus_exp_t e;
      vcnt = 0;
      forever begin
         @(negedge clk);
         if (reset || !mem_valid) begin
            vcnt = 0;
         end else begin
            vcnt++;
            if (mem_ready) begin
               if (exp_bus.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("[TB] FAIL bus_unexpected: actual addr 0x%08h, required no transaction", mem_addr);
               end else begin
                  e = exp_bus.pop_front();
                  check_value("bus_addr", mem_addr, e.addr);
                  check_value("bus_wdata", mem_wdata, e.wdata);
                  check_value("bus_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
                  check_value("bus_cycles", 32'(vcnt), 32'(e.cycles));
               end
               vcnt = 0;
            end
         end
      end
   end

   // Serial monitor: decodes each 8N1 frame on ser_tx; frames cut by reset are discarded.
   initial begin
      logic [7:0] b;
      logic       stop_bit;
      logic       abort;
      time        t0;
      forever begin
         @(negedge clk);
         if (!reset && ser_tx == 1'b0) begin
            t0    = $time;
            abort = 1'b0;
            @(negedge clk);
            abort |= reset;
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge clk);
               abort |= reset;
               b[i] = ser_tx;
            end
            repeat (DIV) @(negedge clk);
            abort |= reset;
            stop_bit = ser_tx;
            if (!abort) begin
               tx_times.push_back(t0);
               if (exp_tx.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("[TB] FAIL tx_unexpected: actual byte 0x%02h, required no byte", b);
               end else begin
                  check_value("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
                  check_value("tx_stop", 32'(stop_bit), 32'd1);
               end
            end
         end
      end
   end

   initial begin
      #(30000 * CLK_T);
      $display("[TB] FAIL watchdog: actual simulation still running, required completion");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int left;
      reset     = 1'b1;
      ser_rx    = 1'b1;
      mem_rdata = 32'h0;
      repeat (3) @(negedge clk);
      check_value("rst_ser_tx", 32'(ser_tx), 32'd1);
      check_value("rst_mem_valid", 32'(mem_valid), 32'd0);
      check_value("rst_mem_addr", mem_addr, 32'h0);
      check_value("rst_mem_wdata", mem_wdata, 32'h0);
      check_value("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
      check_value("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      $display("[TB] write with three wait states");
      ready_delay = 3;
      expect_bus(32'h12345678, 32'hDEADBEEF, 4'hF, 16'd4);
      exp_tx.push_back(8'h4B);
      send_cmd(8'h57, 32'h12345678, 32'hDEADBEEF, 1'b1);
      wait_done("write");
      check_value("write_addr_kept", mem_addr, 32'h12345678);
      check_value("write_valid_low", 32'(mem_valid), 32'd0);

      $display("[TB] zero-wait read with back-to-back response");
      ready_delay = 0;
      mem_rdata   = 32'hCAFEF00D;
      tx_times.delete();
      expect_bus(32'h00000100, 32'hDEADBEEF, 4'h0, 16'd1);
      expect_word(32'hCAFEF00D);
      send_cmd(8'h52, 32'h00000100, 32'h0, 1'b0);
      wait_done("read");
      check_value("read_resp_count", 32'(tx_times.size()), 32'd4);
      if (tx_times.size() == 4)
         for (int i = 1; i < 4; i++)
            check_value("read_resp_spacing", 32'((tx_times[i] - tx_times[i-1]) / CLK_T), 32'(10 * DIV));

      $display("[TB] unknown command then read");
      exp_tx.push_back(8'h3F);
      send_byte(8'hA5, 1'b1, 2 * DIV);
      wait_done("unknown");
      ready_delay = 1;
      mem_rdata   = 32'h11223344;
      expect_bus(32'h20000004, 32'hDEADBEEF, 4'h0, 16'd2);
      expect_word(32'h11223344);
      send_cmd(8'h52, 32'h20000004, 32'h0, 1'b0);
      wait_done("read_after_unknown");

      $display("[TB] partial write abandoned by timeout");
      send_byte(8'h57, 1'b1, 2 * DIV);
      send_byte(8'h10, 1'b1, 2 * DIV);
      send_byte(8'h20, 1'b1, 2 * DIV);
      check_value("partial_busy", 32'(busy), 32'd1);
      repeat (TIMEOUT + 10) @(negedge clk);
      check_value("timeout_busy", 32'(busy), 32'd0);
      ready_delay = 0;
      mem_rdata   = 32'h8BADF00D;
      expect_bus(32'h00000008, 32'hDEADBEEF, 4'h0, 16'd1);
      expect_word(32'h8BADF00D);
      send_cmd(8'h52, 32'h00000008, 32'h0, 1'b0);
      wait_done("read_after_timeout");

      $display("[TB] framing error mid-address and start glitch");
      send_byte(8'h57, 1'b1, 2 * DIV);
      send_byte(8'h11, 1'b1, 2 * DIV);
      send_byte(8'h22, 1'b0, 2 * DIV);
      check_value("frame_err_busy", 32'(busy), 32'd0);
      @(negedge clk);
      ser_rx = 1'b0;
      @(negedge clk);
      ser_rx = 1'b1;
      repeat (20) @(negedge clk);
      check_value("glitch_busy", 32'(busy), 32'd0);
      check_value("glitch_valid", 32'(mem_valid), 32'd0);
      ready_delay = 2;
      mem_rdata   = 32'h01020304;
      expect_bus(32'h0000000C, 32'hDEADBEEF, 4'h0, 16'd3);
      expect_word(32'h01020304);
      send_cmd(8'h52, 32'h0000000C, 32'h0, 1'b0);
      wait_done("read_after_glitch");

      $display("[TB] reset during bus request");
      ready_delay = 1000;
      send_cmd(8'h52, 32'h00000040, 32'h0, 1'b0);
      left = 100;
      while (!mem_valid && left > 0) begin
         @(negedge clk);
         left--;
      end
      check_value("valid_before_reset", 32'(mem_valid), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_value("bus_reset_valid", 32'(mem_valid), 32'd0);
      check_value("bus_reset_ser_tx", 32'(ser_tx), 32'd1);
      check_value("bus_reset_busy", 32'(busy), 32'd0);
      check_value("bus_reset_addr", mem_addr, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      ready_delay = 0;
      repeat (10) @(negedge clk);

      $display("[TB] reset during response byte");
      send_byte(8'hA5, 1'b1, 0);
      left = 40;
      while (ser_tx && left > 0) begin
         @(negedge clk);
         left--;
      end
      check_value("start_bit_seen", 32'(ser_tx), 32'd0);
      reset = 1'b1;
      #1;
      check_value("tx_reset_ser_tx", 32'(ser_tx), 32'd1);
      check_value("tx_reset_busy", 32'(busy), 32'd0);
      check_value("tx_reset_valid", 32'(mem_valid), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      $display("[TB] write after resets");
      expect_bus(32'h30000000, 32'h00000001, 4'hF, 16'd1);
      exp_tx.push_back(8'h4B);
      send_cmd(8'h57, 32'h30000000, 32'h00000001, 1'b1);
      wait_done("write_after_reset");

      repeat (20) @(negedge clk);
      check_value("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
      check_value("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_debug_master.md
# uart_debug_master

UART-driven bus master for the debug path. It receives command frames from an external host over a serial line and executes 32-bit reads and writes on the native memory bus (valid/ready, byte strobes). It then returns a response over the serial line. It is the host-side counterpart to the CPU-side UART peripheral: here the serial link drives the bus, rather than the bus driving the serial link.

## Interface
- DIV, 104, clock cycles per serial bit (fixed at elaboration; legal range 4..65535)
- TIMEOUT, 1000000, idle cycles mid-frame before the parser abandons a partial command
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; all state returns to reset values immediately
- ser_rx  in  1  serial input, idle high, 8N1, LSB first
- ser_tx  out  1  serial output, idle high, 8N1, LSB first; reset value 1
- mem_valid  out  1  bus request; reset 0
- mem_ready  in  1  bus completion, sampled only while mem_valid=1
- mem_addr  out  32  byte address; reset 0
- mem_wdata  out  32  write data; reset 0
- mem_wstrb  out  4  4'hF for write, 4'h0 for read; reset 0
- mem_rdata  in  32  read data, valid in the cycle mem_valid & mem_ready
- busy  out  1  high from the first command byte accepted until the last response stop bit completes; reset 0

## Operation
- RX front end
  - ser_rx passes through a 2-FF synchronizer; all RX decisions use the synchronized value.
  - A falling edge (1->0) in the idle state starts a bit counter. The start bit is resampled DIV/2 cycles later; if it is high, treat it as a glitch and return to idle.
  - Eight data bits are sampled every DIV cycles after the start-bit midpoint. The stop bit is sampled DIV cycles after the last data bit.
  - Stop bit = 1: emit a one-cycle rx_byte strobe with the data.
  - Stop bit = 0: framing error. Discard the byte and force the parser to S_CMD.
- Parser FSM states: S_CMD, S_ADDR, S_DATA, S_BUS, S_RESP.
  - S_CMD, byte 0x52 ('R'): read; go to S_ADDR.
  - S_CMD, byte 0x57 ('W'): write; go to S_ADDR.
  - S_CMD, any other byte: queue response 0x3F ('?'); go to S_RESP.
  - S_ADDR: collect 4 bytes, little-endian, into mem_addr. Read goes to S_BUS; write goes to S_DATA.
  - S_DATA: collect 4 bytes, little-endian, into mem_wdata; go to S_BUS.
  - S_BUS: assert mem_valid with mem_wstrb = write ? 4'hF : 4'h0. Hold mem_valid, mem_addr, mem_wdata and mem_wstrb stable until mem_ready=1. On that cycle capture mem_rdata (read only).
  - S_BUS exit, write: queue response 0x4B ('K').
  - S_BUS exit, read: queue 4 bytes, rdata[7:0] first.
  - S_RESP: transmit the queued bytes back-to-back, then return to S_CMD.
- RX bytes arriving in S_BUS or S_RESP are dropped; the parser does not change state.
- Timeout: in S_ADDR or S_DATA, TIMEOUT cycles without an rx_byte strobe returns the parser to S_CMD with no response. The timeout counter clears on every rx_byte strobe.
- TX: 10-bit shift register {1, data, 0}; each bit lasts exactly DIV cycles; ser_tx is registered.
- mem_addr and mem_wdata retain their last values after a transaction. No alignment check is performed; the address is passed through as received.

## Timing
- RX strobe fires DIV/2 + 9*DIV cycles (±2 for synchronizer) after the ser_rx falling edge.
- mem_valid rises on the clock edge following the rx_byte strobe of the final command byte.
- mem_valid falls on the clock edge after the cycle where mem_valid & mem_ready = 1. A zero-wait-state slave (mem_ready already high) gives a 1-cycle transaction.
- The first response start bit (ser_tx=0) begins on the clock edge after the handshake cycle, or after the rx_byte strobe for an unknown command.
- Each response byte occupies 10*DIV cycles. The next start bit follows the previous stop bit with no gap. busy falls at the end of the last stop bit.
- Reset asserted mid-transfer: ser_tx=1 and mem_valid=0 immediately. The partial frame is lost and no response is sent.

## Test plan
- DIV=4. Send 'W', 78 56 34 12, EF BE AD DE; mem_ready after 3 cycles -> exactly one bus cycle with addr=0x12345678, wdata=0xDEADBEEF, wstrb=F; ser_tx returns 0x4B.
- DIV=4. Send 'R', 00 01 00 00; mem_rdata=0xCAFEF00D with zero wait -> mem_valid high for 1 cycle, wstrb=0; ser_tx returns 0D F0 FE CA, back-to-back.
- Send 0xA5 -> no bus activity; response 0x3F; next valid 'R' command executes normally.
- Send 'W' plus 2 address bytes, then idle TIMEOUT+10 cycles, then a full 'R' command -> no response for the partial command; the read executes at the new address.
- Send a byte with stop bit forced 0 mid-address, then a 1-cycle low glitch on ser_rx -> byte discarded, parser back at S_CMD, glitch ignored, no bus activity.
- Assert reset while mem_valid=1 and while ser_tx is mid-byte -> mem_valid=0, ser_tx=1, busy=0 asynchronously; a subsequent command completes correctly.
